// File: rtl/d2s_sched_pkg.sv
// Shared widths and FSM encoding for the double-to-sign-magnitude converter scheduler.
package d2s_sched_pkg;
  localparam int DOUBLE_W = 64;
  localparam int SIG_W    = 16;
  localparam int CNT_W    = 13;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;
endpackage

// File: rtl/d2s_conv_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first eligible requester at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] eligible_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [IDX_W-1:0] idx_o
);
  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    sum     = '0;
    cand    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, ptr_i} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(N_REQ)) sum = sum - (IDX_W+1)'(N_REQ);
      cand = sum[IDX_W-1:0];
      if (!found && eligible_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = cand;
      end
    end
  end
endmodule

// File: rtl/d2s_conv_scheduler.sv
// Time-shares one registered double-to-sig16 converter among N_REQ requesters,
// serving each at most once per sampling frame and flagging those left unserved.
module d2s_conv_scheduler
  import d2s_sched_pkg::*;
#(
  parameter int               N_REQ      = 4,
  parameter logic [CNT_W-1:0] GRANT_LAST = 13'd4000
) (
  input  logic                      clk_operation,
  input  logic                      rst,
  input  logic [CNT_W-1:0]          sampling_cycle_counter,
  input  logic [N_REQ-1:0]          req,
  input  logic [DOUBLE_W*N_REQ-1:0] req_double,
  output logic [N_REQ-1:0]          ack,
  output logic [SIG_W-1:0]          rsp_sig16b,
  output logic [N_REQ-1:0]          overrun,
  output logic                      conv_rst,
  output logic                      conv_enable,
  output logic [DOUBLE_W-1:0]       conv_double,
  input  logic [SIG_W-1:0]          conv_sig16b
);
  localparam int IDX_W = $clog2(N_REQ);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     gidx_q, gidx_d;
  logic [N_REQ-1:0]     served_q, served_d;
  logic [N_REQ-1:0]     ack_q, ack_d;
  logic [N_REQ-1:0]     overrun_q, overrun_d;
  logic [SIG_W-1:0]     rsp_q, rsp_d;
  logic                 en_q, en_d;
  logic [DOUBLE_W-1:0]  dbl_q, dbl_d;

  logic [N_REQ-1:0]     eligible, arb_grant, in_flight;
  logic [IDX_W-1:0]     arb_idx;
  logic [DOUBLE_W-1:0]  operand [N_REQ];

  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] g);
    if (int'(g) == N_REQ - 1) return '0;
    return g + 1'b1;
  endfunction

  for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
    assign operand[k] = req_double[k*DOUBLE_W +: DOUBLE_W];
  end

  assign eligible = req & ~served_q;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .eligible_i (eligible),
    .ptr_i      (ptr_q),
    .grant_o    (arb_grant),
    .idx_o      (arb_idx)
  );

  // The requester owning the converter between grant and ack.
  always_comb begin
    in_flight = '0;
    if (state_q != IDLE) in_flight[gidx_q] = 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gidx_d    = gidx_q;
    served_d  = served_q;
    ack_d     = '0;
    overrun_d = '0;
    rsp_d     = rsp_q;
    en_d      = 1'b0;
    dbl_d     = dbl_q;

    unique case (state_q)
      IDLE: begin
        if ((|arb_grant) && (sampling_cycle_counter <= GRANT_LAST)) begin
          en_d    = 1'b1;
          dbl_d   = operand[arb_idx];
          ptr_d   = next_ptr(arb_idx);
          gidx_d  = arb_idx;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        rsp_d            = conv_sig16b;
        ack_d[gidx_q]    = 1'b1;
        served_d[gidx_q] = 1'b1;
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Frame start: an in-flight transaction is charged to the new frame.
    if (sampling_cycle_counter == '0) begin
      overrun_d = req & ~served_q & ~in_flight;
      served_d  = in_flight;
    end
  end

  always_ff @(posedge clk_operation) begin
    if (!rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gidx_q    <= '0;
      served_q  <= '0;
      ack_q     <= '0;
      overrun_q <= '0;
      rsp_q     <= '0;
      en_q      <= 1'b0;
      dbl_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gidx_q    <= gidx_d;
      served_q  <= served_d;
      ack_q     <= ack_d;
      overrun_q <= overrun_d;
      rsp_q     <= rsp_d;
      en_q      <= en_d;
      dbl_q     <= dbl_d;
    end
  end

  assign conv_rst    = ~rst;
  assign ack         = ack_q;
  assign overrun     = overrun_q;
  assign rsp_sig16b  = rsp_q;
  assign conv_enable = en_q;
  assign conv_double = dbl_q;
endmodule

// File: doc/d2s_conv_scheduler.md
# d2s_conv_scheduler

Time-shares the single double-to-16-bit sign-magnitude converter among up to N_REQ datapath requesters, for example the echo estimate, the error signal and the output monitor. Each requester is served at most once per sampling frame. The block arbitrates round-robin, drives the converter's enable and operand, and absorbs the converter's one-cycle register lag. It returns each result with a one-cycle ack pulse and flags requesters left unserved at the frame boundary.

## Interface
- N_REQ, 4: number of requesters (2..8).
- GRANT_LAST, 13'd4000: last sampling_cycle_counter value at which a new grant may start.
- clk_operation  in  1  operation clock.
- rst  in  1  reset, synchronous, active-low.
- sampling_cycle_counter  in  13  frame position; value 0 marks frame start.
- req  in  N_REQ  level request per requester.
- req_double  in  64*N_REQ  operand of requester i at [64i+63:64i].
- ack  out  N_REQ  one-cycle pulse, one-hot; result valid.
- rsp_sig16b  out  16  converted value; valid while any ack bit is high.
- overrun  out  N_REQ  one-cycle pulse at frame start, one bit per unserved requester.
- conv_rst  out  1  converter reset, active-high; equals ~rst, combinational.
- conv_enable  out  1  converter enable, registered.
- conv_double  out  64  converter operand, registered.
- conv_sig16b  in  16  converter result.

## Operation
- **Requester contract.** Hold req[i] and req_double[i] stable until ack[i]. Drop req[i] no later than the cycle after ack[i].
- **FSM states:** IDLE, ISSUE, WAIT.
- **IDLE.**
  - Eligible requesters: req & ~served.
  - A grant is made only when sampling_cycle_counter <= GRANT_LAST.
  - The round-robin picker selects g starting at pointer ptr.
  - On a grant: conv_enable <= 1, conv_double <= req_double[g], ptr <= (g+1) mod N_REQ, state -> ISSUE.
- **ISSUE** (converter registers the operand at the end of this cycle): conv_enable <= 0, state -> WAIT.
- **WAIT** (conv_sig16b is valid this cycle): rsp_sig16b <= conv_sig16b, ack[g] <= 1, served[g] <= 1, state -> IDLE.
- **Outputs outside these transitions.** ack and overrun are 0 except for their single-cycle pulse. rsp_sig16b holds its last value.
- **Frame start** (cycle with sampling_cycle_counter == 0):
  - overrun[i] <= req[i] & ~served[i], excluding the requester currently in ISSUE/WAIT.
  - served <= 0, except the in-flight requester's bit, which is set, so its ack counts toward the new frame.
  - Any transaction in flight completes normally.
- **Simultaneous events.** A frame start in the same cycle as an ack applies both: the ack bit is cleared from served unless it belongs to the in-flight requester, which it no longer does.
- **Reset** (rst == 0 at clk edge), including mid-transaction:
  - state IDLE, ptr 0, served 0.
  - ack 0, overrun 0, rsp_sig16b 0.
  - conv_enable 0, conv_double 0.
  - conv_rst is 1 while rst is low.
  - Any pending transaction is dropped without ack.
- **Width rules.** Operands and results pass through unmodified. No arithmetic in this block other than the ptr wrap modulo N_REQ.

## Timing
- Latency: requester eligible in IDLE cycle t, then conv_enable high in cycle t+1, ack[g] and rsp_sig16b in cycle t+3.
- Throughput: one conversion per 3 cycles. IDLE in the ack cycle may grant the next requester, so the next ack comes at t+6.
- An acked requester whose req is still high in the ack cycle is not regranted until the next frame.
- No grant starts at counter > GRANT_LAST. A transaction started at GRANT_LAST acks at GRANT_LAST+3.
- The first active cycle after reset release is IDLE and may grant.

## Structure
- Package d2s_sched_pkg:
  - state encoding IDLE/ISSUE/WAIT;
  - DOUBLE_W=64, SIG_W=16, CNT_W=13.
- Sub-module rr_arbiter: combinational round-robin picker. Inputs: eligible mask and ptr. Outputs: one-hot grant and its index.
- The converter is instantiated at the parent level, not inside this block.

## Test plan
- **Single request.** req[0] at counter 10 with 64'h3FF0000000000000 (1.0) -> conv_enable in cycle 11, ack[0] and rsp_sig16b=16'h0001 in cycle 13.
- **Round-robin.** req=4'b1111 with operands 3.0, -2.0, 65536.0, 0.5 -> acks in order 0,1,2,3 spaced 3 cycles apart.
  - Responses: 16'h0003, 16'h8002, 16'h7FFF, 16'h0000.
  - ptr returns to 0.
- **Once per frame.** req[1] held high after ack -> no second ack[1] until counter wraps to 0 and the frame restarts.
- **Window and overrun.**
  - With GRANT_LAST=20, req[2] raised at counter 21 -> no grant.
  - At next counter==0 -> overrun=4'b0100 for one cycle, then grant at counter 0 and ack at 3.
- **Reset mid-transaction.** rst low during WAIT -> next cycle ack=0, conv_enable=0, rsp_sig16b=0, conv_rst=1. After release, the held request is regranted from ptr 0.
